// File: rtl/sync_fifo_pkg.sv
// Shared definitions for sync_fifo_flags.
//   - ptr_width():         pointer/count width for a given depth (one extra MSB for wrap).
//   - FIFO_MODE_STD/FWFT:  values for the FWFT parameter.
//   - fifo_params_legal(): elaboration-time legality check used by the top.
package sync_fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_params_legal(input int unsigned width,
                                             input int unsigned depth,
                                             input int unsigned af_level,
                                             input int unsigned ae_level,
                                             input int unsigned fwft);
        return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (af_level <= depth) && (ae_level < af_level) && (fwft <= 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM backing sync_fifo_flags.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i   synchronous write port
//   rd_en_i/rd_addr_i      read port; rd_en_i only matters when REG_RD = 1
//   rd_data_o              registered read data (REG_RD = 1) or combinational (REG_RD = 0)
// The array itself is never reset.
module fifo_mem #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 32,
    parameter bit          REG_RD = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    if (REG_RD) begin : gen_reg_rd
        logic [WIDTH-1:0] rd_data_q, rd_data_d;

        always_comb begin
            rd_data_d = rd_data_q;
            if (rd_en_i) begin
                rd_data_d = mem_q[rd_addr_i];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign rd_data_o = rd_data_q;
    end else begin : gen_comb_rd
        assign rd_data_o = mem_q[rd_addr_i];
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags,
// sticky overflow/underflow, synchronous flush and optional first-word-fall-through.
// Ports:
//   CLK, RST                 clock (rising edge), async active-low reset
//   SOFT_CLR                 synchronous flush, wins over WR_EN/R_EN
//   DATA_IN, WR_EN           write data and request
//   R_EN                     read (pop) request
//   DATA_out                 read data (registered, or head entry in FWFT mode)
//   FULL_FLAG, EMPTY_FLAG, ALMOST_FULL, ALMOST_EMPTY, COUNT   registered status
//   OVERFLOW, UNDERFLOW      sticky dropped-write / dropped-read indicators
//   PARITY_ERR               only with SYNC_FIFO_PARITY_EN defined: one-cycle pulse when a
//                            read returns a word whose stored even parity does not match
// Build option: define SYNC_FIFO_PARITY_EN to add a parity bit per entry and PARITY_ERR.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4,
    parameter int unsigned FWFT     = FIFO_MODE_STD
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SOFT_CLR,
    input  logic [WIDTH-1:0]       DATA_IN,
    input  logic                   WR_EN,
    input  logic                   R_EN,
    output logic [WIDTH-1:0]       DATA_out,
    output logic                   FULL_FLAG,
    output logic                   EMPTY_FLAG,
    output logic                   ALMOST_FULL,
    output logic                   ALMOST_EMPTY,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVERFLOW,
`ifdef SYNC_FIFO_PARITY_EN
    output logic                   PARITY_ERR,
`endif
    output logic                   UNDERFLOW
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);
`ifdef SYNC_FIFO_PARITY_EN
    localparam int unsigned MW = WIDTH + 1;
`else
    localparam int unsigned MW = WIDTH;
`endif

    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT    = PW'(AE_LEVEL);

    if (!fifo_params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : gen_param_err
        $error("sync_fifo_flags: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL/FWFT combination");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_acc, rd_acc;
    logic [MW-1:0] wr_word, rd_word;

    always_comb begin
        // A flush cycle accepts nothing, so the RAM and read register stay untouched.
        rd_acc = R_EN && !empty_q && !SOFT_CLR;
        wr_acc = WR_EN && (!full_q || rd_acc) && !SOFT_CLR;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (SOFT_CLR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            if (WR_EN && !wr_acc) ovf_d = 1'b1;
            if (R_EN && !rd_acc)  unf_d = 1'b1;
        end

        // Pointers wrap modulo 2*DEPTH, so the difference is the occupancy 0..DEPTH.
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (count_d == DEPTH_CNT);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_CNT);
        aempty_d = (count_d <= AE_CNT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    assign wr_word = {^DATA_IN, DATA_IN};
`else
    assign wr_word = DATA_IN;
`endif

    fifo_mem #(
        .WIDTH  (MW),
        .DEPTH  (DEPTH),
        .REG_RD (FWFT == FIFO_MODE_STD)
    ) u_mem (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_word),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_word)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : gen_fwft_out
        // Stale RAM contents are masked so an empty FIFO always presents zero.
        assign DATA_out = empty_q ? '0 : rd_word[WIDTH-1:0];
    end else begin : gen_std_out
        assign DATA_out = rd_word[WIDTH-1:0];
    end

`ifdef SYNC_FIFO_PARITY_EN
    if (FWFT == FIFO_MODE_FWFT) begin : gen_fwft_par
        // The popped word is the head seen before the edge; flag it as the edge advances.
        logic par_err_q, par_err_d;
        assign par_err_d = rd_acc && (^rd_word);
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) par_err_q <= 1'b0;
            else      par_err_q <= par_err_d;
        end
        assign PARITY_ERR = par_err_q;
    end else begin : gen_std_par
        // Both terms are flop outputs: the read-valid flag and the registered RAM word.
        logic rd_vld_q, rd_vld_d;
        assign rd_vld_d = rd_acc;
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) rd_vld_q <= 1'b0;
            else      rd_vld_q <= rd_vld_d;
        end
        assign PARITY_ERR = rd_vld_q && (^rd_word);
    end
`endif

    assign COUNT        = count_q;
    assign FULL_FLAG    = full_q;
    assign EMPTY_FLAG   = empty_q;
    assign ALMOST_FULL  = afull_q;
    assign ALMOST_EMPTY = aempty_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO; successor to the team's dual-clock FIFO for same-domain buffering.
- Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow, synchronous flush and a first-word-fall-through (FWFT) mode.
- Sits between a producer and consumer sharing CLK, e.g. packet staging ahead of a serialiser.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 32, number of entries; power of two, >=4
- AF_LEVEL, DEPTH-4, ALMOST_FULL asserted when COUNT >= AF_LEVEL
- AE_LEVEL, 4, ALMOST_EMPTY asserted when COUNT <= AE_LEVEL
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous active-low reset
- SOFT_CLR  in  1  synchronous flush, active-high
- DATA_IN  in  WIDTH  write data
- WR_EN  in  1  write request
- R_EN  in  1  read request
- DATA_out  out  WIDTH  read data
- FULL_FLAG  out  1  COUNT == DEPTH
- EMPTY_FLAG  out  1  COUNT == 0
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL
- COUNT  out  $clog2(DEPTH)+1  current occupancy
- OVERFLOW  out  1  sticky; a write was dropped
- UNDERFLOW  out  1  sticky; a read was dropped

Behaviour:
- Reset (RST low, async): pointers = 0, COUNT = 0, DATA_out = 0, EMPTY_FLAG = 1, ALMOST_EMPTY = 1, FULL_FLAG = 0, ALMOST_FULL = 0, OVERFLOW = 0, UNDERFLOW = 0. Memory contents are not reset.
- Pointers: $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty. Wrap is natural modulo 2*DEPTH.
- Write accepted = WR_EN && (!FULL_FLAG || read accepted in the same cycle). Accepted data is stored at wr_ptr, then wr_ptr increments.
- Read accepted = R_EN && !EMPTY_FLAG.
- Standard mode (FWFT=0):
  - DATA_out updates on the edge after an accepted read (1-cycle latency).
  - DATA_out holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - DATA_out always shows the head entry whenever EMPTY_FLAG = 0.
  - R_EN acts as a pop; the next entry is visible after the same edge.
  - A write into an empty FIFO is visible on DATA_out and clears EMPTY_FLAG one cycle after the write edge.
- COUNT: +1 on write only, -1 on read only, unchanged on both or neither. All flags are registered and derive from the next-state COUNT, so they are valid in the same cycle COUNT updates.
- Full with WR_EN and R_EN together: both are accepted; COUNT stays DEPTH; no OVERFLOW.
- Empty with WR_EN and R_EN together: write accepted, read dropped, UNDERFLOW set.
  - Standard mode: DATA_out is unchanged.
  - FWFT mode: the data appears next cycle.
- WR_EN while full without a read: write dropped, OVERFLOW set, memory untouched.
- R_EN while empty: read dropped, UNDERFLOW set, DATA_out unchanged.
- OVERFLOW/UNDERFLOW are cleared only by RST or SOFT_CLR.
- SOFT_CLR: takes priority over WR_EN/R_EN in that cycle. Next edge restores all reset values, except DATA_out, which holds in standard mode and reads 0 in FWFT mode.
- RST asserted mid-operation discards all contents immediately; the first write after release lands at address 0.
- Illegal parameters (DEPTH not a power of two, AF_LEVEL > DEPTH, AE_LEVEL >= AF_LEVEL) are rejected by an elaboration-time check.

Optional Feature:
- Macro: SYNC_FIFO_PARITY_EN.
- Defined:
  - Each entry stores WIDTH+1 bits; the extra bit is even parity of DATA_IN, computed at write.
  - Adds output port PARITY_ERR (1 bit), registered.
  - PARITY_ERR pulses high for one cycle aligned with the DATA_out update of any read whose stored parity mismatches.
  - Reset value 0.
- Undefined: no extra storage bit and no PARITY_ERR port.

Decomposition:
- Package sync_fifo_pkg holds:
  - the pointer-width helper function (clog2-based);
  - mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1;
  - the parameter-legality check function.
- Sub-module fifo_mem: simple dual-port RAM, WIDTH(+1) x DEPTH.
  - Synchronous write.
  - Read is synchronous for FWFT=0 and combinational for FWFT=1.
  - Keeps the control logic independent of the RAM implementation.

Test Plan:
- Reset then R_EN=1 for 2 cycles -> EMPTY_FLAG=1, COUNT=0, UNDERFLOW=1, DATA_out=0.
- Write 0xFF, then 0x81; then read twice (FWFT=0) -> DATA_out=0xFF one cycle after the first read, 0x81 after the second; EMPTY_FLAG=1 after the second read; FULL_FLAG=0 throughout.
- Write 32 random words (DEPTH=32) -> ALMOST_FULL rises when COUNT reaches 28, FULL_FLAG=1 at COUNT=32. A 33rd write sets OVERFLOW=1 with COUNT=32. Reading all 32 words returns them in the same order and ends with EMPTY_FLAG=1.
- Full FIFO, WR_EN=R_EN=1 for 5 cycles -> COUNT stays 32, OVERFLOW stays 0, read order preserved across pointer wrap.
- FWFT=1: write 0xA5 into empty FIFO -> DATA_out=0xA5, EMPTY_FLAG=0 one cycle after the write edge; one R_EN -> EMPTY_FLAG=1.
- With 10 entries stored, SOFT_CLR=1 for one cycle -> COUNT=0, EMPTY_FLAG=1, OVERFLOW/UNDERFLOW=0. The next write+read returns the newly written word.
